// File: rtl/order_book_sequencer.sv
// Buffers the add and delete/execute streams and issues single-cycle, gap-spaced updates into order_book.
// Define OB_SEQ_DEL_PRIO_EN for strict delete/execute priority; otherwise arbitration is round-robin.

module order_book_sequencer_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 81
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_next, rd_next;
  logic             do_push, do_pop, full_next;

  assign do_push = push & ready;
  assign do_pop  = pop & ~empty;
  assign wr_next = wr_ptr + (AW+1)'(do_push);
  assign rd_next = rd_ptr + (AW+1)'(do_pop);
  // The extra MSB separates full (MSBs differ) from empty (pointers equal).
  assign full_next = (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign dout      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready  <= 1'b1;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      ready  <= ~full_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module order_book_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clkIn,
  input  logic        rstNIn,
  input  logic        addValidIn,
  output logic        addReadyOut,
  input  logic [15:0] addLocateIn,
  input  logic [31:0] addPriceIn,
  input  logic [31:0] addSharesIn,
  input  logic        addBuySellIn,
  input  logic        delValidIn,
  output logic        delReadyOut,
  input  logic [15:0] delLocateIn,
  input  logic [31:0] delPriceIn,
  input  logic [31:0] delSharesIn,
  input  logic        delBuySellIn,
  output logic        addValidOut,
  output logic        delExecValidOut,
  output logic [15:0] locateOut,
  output logic [31:0] priceOut,
  output logic [31:0] sharesOut,
  output logic        buySellOut,
  output logic [15:0] mapLocateOut,
  output logic [31:0] mapPriceOut,
  output logic [31:0] mapSharesOut,
  output logic        mapBuySellOut,
  output logic        busyOut
);
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 2) ? GW'(GAP_CYCLES - 2) : '0;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state;
  logic [GW-1:0] gap_cnt;
  logic        last_del;
  logic [80:0] add_data, del_data;
  logic        add_empty, del_empty;
  logic        issue, grant_del;

  assign issue = (state == IDLE) && !(add_empty && del_empty);

`ifdef OB_SEQ_DEL_PRIO_EN
  assign grant_del = ~del_empty;
`else
  // Contested grants go to the stream that did not win last time.
  assign grant_del = ~del_empty & (add_empty | ~last_del);
`endif

  order_book_sequencer_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(81)) add_fifo (
    .clk   (clkIn),
    .rst_n (rstNIn),
    .push  (addValidIn),
    .din   ({addLocateIn, addPriceIn, addSharesIn, addBuySellIn}),
    .pop   (issue & ~grant_del),
    .dout  (add_data),
    .empty (add_empty),
    .ready (addReadyOut)
  );

  order_book_sequencer_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(81)) del_fifo (
    .clk   (clkIn),
    .rst_n (rstNIn),
    .push  (delValidIn),
    .din   ({delLocateIn, delPriceIn, delSharesIn, delBuySellIn}),
    .pop   (issue & grant_del),
    .dout  (del_data),
    .empty (del_empty),
    .ready (delReadyOut)
  );

  assign busyOut = (state == HOLD) | ~add_empty | ~del_empty;

  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      state           <= IDLE;
      gap_cnt         <= '0;
      last_del        <= 1'b0;
      addValidOut     <= 1'b0;
      delExecValidOut <= 1'b0;
      locateOut       <= '0;
      priceOut        <= '0;
      sharesOut       <= '0;
      buySellOut      <= 1'b0;
      mapLocateOut    <= '0;
      mapPriceOut     <= '0;
      mapSharesOut    <= '0;
      mapBuySellOut   <= 1'b0;
    end else begin
      addValidOut     <= 1'b0;
      delExecValidOut <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            if (grant_del) begin
              {mapLocateOut, mapPriceOut, mapSharesOut, mapBuySellOut} <= del_data;
              delExecValidOut <= 1'b1;
              last_del        <= 1'b1;
            end else begin
              {locateOut, priceOut, sharesOut, buySellOut} <= add_data;
              addValidOut <= 1'b1;
              last_del    <= 1'b0;
            end
            // HOLD covers GAP_CYCLES-1 edges so the next IDLE issue is GAP_CYCLES later.
            if (GAP_CYCLES > 1) begin
              state   <= HOLD;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        HOLD: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_order_book_sequencer.sv
// Self-checking bench for order_book_sequencer: randomized traffic against a timestamp/queue reference model.
module tb_order_book_sequencer;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        add_valid, del_valid;
  logic [15:0] add_loc, del_loc;
  logic [31:0] add_price, add_shares, del_price, del_shares;
  logic        add_bs, del_bs;

  logic        add_ready, del_ready, add_v_o, del_v_o, busy;
  logic [15:0] loc_o, map_loc_o;
  logic [31:0] price_o, shares_o, map_price_o, map_shares_o;
  logic        bs_o, map_bs_o;
  logic [80:0] add_pl_o, map_pl_o;
  assign add_pl_o = {loc_o, price_o, shares_o, bs_o};
  assign map_pl_o = {map_loc_o, map_price_o, map_shares_o, map_bs_o};

  // Second instance with GAP_CYCLES=1, add stream only.
  logic        g1_add_valid;
  logic [31:0] g1_price;
  logic        g1_add_ready, g1_del_ready, g1_add_v, g1_del_v, g1_busy;
  logic [15:0] g1_loc, g1_mloc;
  logic [31:0] g1_price_o, g1_shares, g1_mprice, g1_mshares;
  logic        g1_bs, g1_mbs;

  int checks = 0;
  int errors = 0;

  // Reference model: per-stream queues plus time of last issue.
  logic [80:0] m_addq[$];
  logic [80:0] m_delq[$];
  logic [80:0] e_add_pl, e_map_pl;
  bit e_add_v, e_del_v, e_add_rdy, e_del_rdy, e_busy, m_last_del;
  int cyc = 0;
  int last_issue = -1000;

  order_book_sequencer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clkIn(clk), .rstNIn(rst_n),
    .addValidIn(add_valid), .addReadyOut(add_ready),
    .addLocateIn(add_loc), .addPriceIn(add_price), .addSharesIn(add_shares), .addBuySellIn(add_bs),
    .delValidIn(del_valid), .delReadyOut(del_ready),
    .delLocateIn(del_loc), .delPriceIn(del_price), .delSharesIn(del_shares), .delBuySellIn(del_bs),
    .addValidOut(add_v_o), .delExecValidOut(del_v_o),
    .locateOut(loc_o), .priceOut(price_o), .sharesOut(shares_o), .buySellOut(bs_o),
    .mapLocateOut(map_loc_o), .mapPriceOut(map_price_o), .mapSharesOut(map_shares_o), .mapBuySellOut(map_bs_o),
    .busyOut(busy)
  );

  order_book_sequencer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(1)) dut_gap1 (
    .clkIn(clk), .rstNIn(rst_n),
    .addValidIn(g1_add_valid), .addReadyOut(g1_add_ready),
    .addLocateIn(16'd7), .addPriceIn(g1_price), .addSharesIn(32'd1), .addBuySellIn(1'b0),
    .delValidIn(1'b0), .delReadyOut(g1_del_ready),
    .delLocateIn(16'd0), .delPriceIn(32'd0), .delSharesIn(32'd0), .delBuySellIn(1'b0),
    .addValidOut(g1_add_v), .delExecValidOut(g1_del_v),
    .locateOut(g1_loc), .priceOut(g1_price_o), .sharesOut(g1_shares), .buySellOut(g1_bs),
    .mapLocateOut(g1_mloc), .mapPriceOut(g1_mprice), .mapSharesOut(g1_mshares), .mapBuySellOut(g1_mbs),
    .busyOut(g1_busy)
  );

  task automatic model_update();
    logic take_del;
    logic [80:0] it;
    if (!rst_n) begin
      m_addq.delete();
      m_delq.delete();
      m_last_del = 1'b0;
      last_issue = -1000;
      e_add_v = 0; e_del_v = 0;
      e_add_pl = '0; e_map_pl = '0;
      e_add_rdy = 1; e_del_rdy = 1;
    end else begin
      e_add_v = 0; e_del_v = 0;
      if ((cyc - last_issue) >= GAP && (m_addq.size() > 0 || m_delq.size() > 0)) begin
`ifdef OB_SEQ_DEL_PRIO_EN
        take_del = (m_delq.size() > 0);
`else
        if (m_addq.size() > 0 && m_delq.size() > 0) take_del = !m_last_del;
        else take_del = (m_delq.size() > 0);
`endif
        if (take_del) begin
          it = m_delq.pop_front();
          e_map_pl = it;
          e_del_v = 1;
        end else begin
          it = m_addq.pop_front();
          e_add_pl = it;
          e_add_v = 1;
        end
        m_last_del = take_del;
        last_issue = cyc;
      end
      if (add_valid && e_add_rdy) m_addq.push_back({add_loc, add_price, add_shares, add_bs});
      if (del_valid && e_del_rdy) m_delq.push_back({del_loc, del_price, del_shares, del_bs});
      e_add_rdy = (m_addq.size() < DEPTH);
      e_del_rdy = (m_delq.size() < DEPTH);
    end
    e_busy = ((cyc - last_issue) < GAP - 1) || m_addq.size() > 0 || m_delq.size() > 0;
    cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic rand_payloads();
    add_loc = 16'($urandom); add_price = $urandom; add_shares = $urandom; add_bs = 1'($urandom);
    del_loc = 16'($urandom); del_price = $urandom; del_shares = $urandom; del_bs = 1'($urandom);
  endtask

  task automatic drain();
    add_valid = 0;
    del_valid = 0;
    repeat (2 * DEPTH * GAP + GAP) cycle();
  endtask

  task automatic test_reset();
    rst_n = 0;
    add_valid = 0; del_valid = 0; g1_add_valid = 0; g1_price = 0;
    rand_payloads();
    cycle();
    cycle();
    checks++;
    if ({add_v_o, del_v_o, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_valids_busy: got %b expected 000", {add_v_o, del_v_o, busy});
    end
    checks++;
    if (add_pl_o !== 81'd0 || map_pl_o !== 81'd0) begin
      errors++; $display("FAIL reset_payload: got add %h map %h expected 0", add_pl_o, map_pl_o);
    end
    checks++;
    if ({add_ready, del_ready, g1_add_ready, g1_del_ready} !== 4'b1111) begin
      errors++; $display("FAIL reset_ready: got %b expected 1111", {add_ready, del_ready, g1_add_ready, g1_del_ready});
    end
    rst_n = 1;
    cycle();
    checks++;
    if ({add_v_o, del_v_o, g1_add_v, g1_del_v} !== 4'b0000) begin
      errors++; $display("FAIL reset_no_pulse: got %b expected 0000", {add_v_o, del_v_o, g1_add_v, g1_del_v});
    end
  endtask

  task automatic test_single_add();
    add_valid = 1; add_loc = 16'd5; add_price = 32'd100; add_shares = 32'd10; add_bs = 1'b1;
    cycle();
    add_valid = 0;
    checks++;
    if (add_v_o !== 1'b0) begin errors++; $display("FAIL single_early: addValidOut got %b expected 0", add_v_o); end
    cycle();
    checks++;
    if (add_v_o !== 1'b1 || del_v_o !== 1'b0) begin
      errors++; $display("FAIL single_pulse: add %b del %b expected 1 0", add_v_o, del_v_o);
    end
    checks++;
    if (add_pl_o !== {16'd5, 32'd100, 32'd10, 1'b1}) begin
      errors++; $display("FAIL single_payload: got loc %0d price %0d shares %0d bs %b expected 5 100 10 1", loc_o, price_o, shares_o, bs_o);
    end
    checks++;
    if (map_pl_o !== 81'd0) begin errors++; $display("FAIL single_map: got %h expected 0", map_pl_o); end
    cycle();
    checks++;
    if (add_v_o !== 1'b0 || price_o !== 32'd100) begin
      errors++; $display("FAIL single_hold: add %b price %0d expected 0 100", add_v_o, price_o);
    end
    repeat (GAP) cycle();
  endtask

  task automatic test_contested();
    int kinds[$];
    int times[$];
    int exp_kind;
    for (int i = 0; i < 26; i++) begin
      rand_payloads();
      add_valid = (i < 3);
      del_valid = (i < 3);
      cycle();
      checks++;
      if (add_v_o !== e_add_v || del_v_o !== e_del_v) begin
        errors++; $display("FAIL contest_valid i=%0d: got %b%b expected %b%b", i, add_v_o, del_v_o, e_add_v, e_del_v);
      end
      checks++;
      if (add_pl_o !== e_add_pl || map_pl_o !== e_map_pl) begin
        errors++; $display("FAIL contest_payload i=%0d: got %h/%h expected %h/%h", i, add_pl_o, map_pl_o, e_add_pl, e_map_pl);
      end
      if (add_v_o === 1'b1) begin kinds.push_back(0); times.push_back(i); end
      if (del_v_o === 1'b1) begin kinds.push_back(1); times.push_back(i); end
    end
    checks++;
    if (kinds.size() != 6) begin errors++; $display("FAIL contest_count: got %0d issues expected 6", kinds.size()); end
    for (int k = 0; k < kinds.size() && k < 6; k++) begin
`ifdef OB_SEQ_DEL_PRIO_EN
      exp_kind = (k < 3) ? 1 : 0;
`else
      exp_kind = (k % 2 == 0) ? 1 : 0;
`endif
      checks++;
      if (kinds[k] != exp_kind || times[k] != 1 + GAP * k) begin
        errors++; $display("FAIL contest_order #%0d: got kind %0d at %0d expected kind %0d at %0d", k, kinds[k], times[k], exp_kind, 1 + GAP * k);
      end
    end
    drain();
  endtask

  task automatic test_full();
    bit saw_low = 0;
    bit saw_rise = 0;
    for (int i = 0; i < 40; i++) begin
      rand_payloads();
      add_valid = 1;
      del_valid = 0;
      cycle();
      checks++;
      if (add_ready !== e_add_rdy) begin
        errors++; $display("FAIL full_ready i=%0d: got %b expected %b", i, add_ready, e_add_rdy);
      end
      checks++;
      if (add_v_o !== e_add_v || add_pl_o !== e_add_pl) begin
        errors++; $display("FAIL full_issue i=%0d: got %b %h expected %b %h", i, add_v_o, add_pl_o, e_add_v, e_add_pl);
      end
      if (add_ready === 1'b0) saw_low = 1;
      if (saw_low && add_ready === 1'b1) saw_rise = 1;
    end
    checks++;
    if (saw_low !== 1'b1 || saw_rise !== 1'b1) begin
      errors++; $display("FAIL full_ready_toggle: low %b rise %b expected 1 1", saw_low, saw_rise);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_payloads();
      add_valid = ($urandom_range(0, 99) < 40);
      del_valid = ($urandom_range(0, 99) < 40);
      cycle();
      checks++;
      if (add_v_o !== e_add_v || del_v_o !== e_del_v) begin
        errors++; $display("FAIL rand_valid i=%0d: got %b%b expected %b%b", i, add_v_o, del_v_o, e_add_v, e_del_v);
      end
      checks++;
      if (add_pl_o !== e_add_pl || map_pl_o !== e_map_pl) begin
        errors++; $display("FAIL rand_payload i=%0d: got %h/%h expected %h/%h", i, add_pl_o, map_pl_o, e_add_pl, e_map_pl);
      end
      checks++;
      if (add_ready !== e_add_rdy || del_ready !== e_del_rdy) begin
        errors++; $display("FAIL rand_ready i=%0d: got %b%b expected %b%b", i, add_ready, del_ready, e_add_rdy, e_del_rdy);
      end
      checks++;
      if (busy !== e_busy) begin errors++; $display("FAIL rand_busy i=%0d: got %b expected %b", i, busy, e_busy); end
      checks++;
      if ((add_v_o & del_v_o) !== 1'b0) begin errors++; $display("FAIL rand_exclusive i=%0d: both valids high", i); end
    end
    drain();
  endtask

  task automatic test_reset_hold();
    for (int i = 0; i < 3; i++) begin
      rand_payloads();
      del_valid = 1;
      cycle();
    end
    del_valid = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rsthold_pre_busy: got %b expected 1", busy); end
    rst_n = 0;
    cycle();
    rst_n = 1;
    checks++;
    if ({add_ready, del_ready, busy} !== 3'b110) begin
      errors++; $display("FAIL rsthold_state: ready/busy got %b expected 110", {add_ready, del_ready, busy});
    end
    for (int i = 0; i < 2 * GAP; i++) begin
      cycle();
      checks++;
      if ({add_v_o, del_v_o, busy} !== 3'b000) begin
        errors++; $display("FAIL rsthold_quiet i=%0d: valids/busy got %b expected 000", i, {add_v_o, del_v_o, busy});
      end
    end
    add_valid = 1; add_price = 32'd777;
    cycle();
    add_valid = 0;
    checks++;
    if (add_v_o !== 1'b0) begin errors++; $display("FAIL rsthold_early: got %b expected 0", add_v_o); end
    cycle();
    checks++;
    if (add_v_o !== 1'b1 || price_o !== 32'd777) begin
      errors++; $display("FAIL rsthold_add: valid %b price %0d expected 1 777", add_v_o, price_o);
    end
    drain();
  endtask

  task automatic test_late_push();
    logic [31:0] p2;
    rand_payloads();
    del_valid = 1;
    cycle();
    del_valid = 0;
    cycle();
    checks++;
    if (del_v_o !== 1'b1) begin errors++; $display("FAIL late_first: got %b expected 1", del_v_o); end
    for (int j = 0; j < GAP - 2; j++) begin
      cycle();
      checks++;
      if (del_v_o !== 1'b0) begin errors++; $display("FAIL late_gap j=%0d: got %b expected 0", j, del_v_o); end
    end
    p2 = $urandom;
    del_price = p2;
    del_valid = 1;
    cycle();
    del_valid = 0;
    checks++;
    if (del_v_o !== 1'b0) begin errors++; $display("FAIL late_early: got %b expected 0", del_v_o); end
    cycle();
    checks++;
    if (del_v_o !== 1'b1 || map_price_o !== p2) begin
      errors++; $display("FAIL late_issue: valid %b price %h expected 1 %h", del_v_o, map_price_o, p2);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      g1_add_valid = (i < 4);
      g1_price = 32'(101 + i);
      cycle();
      checks++;
      if (g1_add_v !== (i >= 1 && i <= 4)) begin
        errors++; $display("FAIL b2b_valid i=%0d: got %b expected %b", i, g1_add_v, (i >= 1 && i <= 4));
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (g1_price_o !== 32'(100 + i) || g1_loc !== 16'd7 || g1_shares !== 32'd1 || g1_bs !== 1'b0) begin
          errors++; $display("FAIL b2b_payload i=%0d: got price %0d expected %0d", i, g1_price_o, 100 + i);
        end
      end
      checks++;
      if (g1_add_ready !== 1'b1 || g1_del_v !== 1'b0) begin
        errors++; $display("FAIL b2b_side i=%0d: ready %b del %b expected 1 0", i, g1_add_ready, g1_del_v);
      end
    end
    g1_add_valid = 0;
    cycle();
    checks++;
    if ({g1_mloc, g1_mprice, g1_mshares, g1_mbs} !== 81'd0 || g1_busy !== 1'b0 || g1_del_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_end: map %h busy %b dready %b expected 0 0 1",
                         {g1_mloc, g1_mprice, g1_mshares, g1_mbs}, g1_busy, g1_del_ready);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_contested();
    test_full();
    test_random();
    test_reset_hold();
    test_late_push();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
